// File: rtl/hc595_chain_tx_if.sv
// Load/ready/done handshake between pattern logic and the hc595_chain_tx serialiser.
// The master supplies the word and the load request; the slave reports ready and done.
interface hc595_chain_tx_if #(
  parameter int CHAIN_W = 14
);
  logic [CHAIN_W-1:0] din;
  logic               load;
  logic               ready;
  logic               done;

  modport master (
    output din,
    output load,
    input  ready,
    input  done
  );

  modport slave (
    input  din,
    input  load,
    output ready,
    output done
  );
endinterface

// File: rtl/hc595_chain_tx.sv
// On-demand serial transmitter for a 74HC595 daisy-chain: shifts a CHAIN_W-bit word on ds/shcp, then pulses stcp.
// Optional PWM dimming on oe_n is compiled in when HC595_DIM_EN is defined.
module hc595_chain_tx #(
  parameter int CHAIN_W   = 14,
  parameter int DIV       = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  hc595_chain_tx_if.slave    bus,
`ifdef HC595_DIM_EN
  input  logic [7:0]         bright,
`endif
  output logic               ds,
  output logic               shcp,
  output logic               stcp,
  output logic               oe_n
);

  localparam int PW   = $clog2(DIV);
  localparam int BW   = (CHAIN_W > 1) ? $clog2(CHAIN_W) : 1;
  localparam int HALF = DIV / 2;

  localparam logic [PW-1:0] PH_LAST    = PW'(DIV - 1);
  localparam logic [PW-1:0] PH_HALF    = PW'(HALF);
  localparam logic [PW-1:0] LATCH_LAST = PW'(HALF - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(CHAIN_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CHAIN_W-1:0] r_sr;
  logic [CHAIN_W-1:0] w_sr_nxt;
  logic [CHAIN_W-1:0] w_sr_adv;
  logic [PW-1:0]      r_phase;
  logic [PW-1:0]      w_phase_nxt;
  logic [PW-1:0]      w_phase_inc;
  logic [BW-1:0]      r_bit;
  logic [BW-1:0]      w_bit_nxt;
  logic               r_ds;
  logic               r_shcp;
  logic               r_stcp;
  logic               r_ready;
  logic               r_done;
  logic               w_ds_nxt;
  logic               w_shcp_nxt;
  logic               w_stcp_nxt;
  logic               w_ready_nxt;
  logic               w_done_nxt;

  // Bit that leaves the chain first for a given register image.
  function automatic logic first_bit(input logic [CHAIN_W-1:0] w);
    return (MSB_FIRST != 0) ? w[CHAIN_W-1] : w[0];
  endfunction

  assign w_sr_adv    = (MSB_FIRST != 0) ? (r_sr << 1) : (r_sr >> 1);
  assign w_phase_inc = r_phase + PW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_phase_nxt = r_phase;
    w_bit_nxt   = r_bit;
    w_ds_nxt    = 1'b0;
    w_shcp_nxt  = 1'b0;
    w_stcp_nxt  = 1'b0;
    w_ready_nxt = 1'b0;
    w_done_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_ready_nxt = 1'b1;
        if (bus.load && r_ready) begin
          w_state_nxt = S_SHIFT;
          w_sr_nxt    = bus.din;
          w_phase_nxt = '0;
          w_bit_nxt   = '0;
          w_ds_nxt    = first_bit(bus.din);
          w_ready_nxt = 1'b0;
        end
      end

      S_SHIFT: begin
        if (r_phase == PH_LAST) begin
          w_phase_nxt = '0;
          if (r_bit == BIT_LAST) begin
            w_state_nxt = S_LATCH;
            w_bit_nxt   = '0;
            w_stcp_nxt  = 1'b1;
          end else begin
            w_bit_nxt = r_bit + BW'(1);
            w_sr_nxt  = w_sr_adv;
            w_ds_nxt  = first_bit(w_sr_adv);
          end
        end else begin
          // shcp goes high for the second half of the bit so ds is stable at the 595 edge.
          w_phase_nxt = w_phase_inc;
          w_ds_nxt    = r_ds;
          w_shcp_nxt  = (w_phase_inc >= PH_HALF);
        end
      end

      S_LATCH: begin
        if (r_phase == LATCH_LAST) begin
          w_state_nxt = S_IDLE;
          w_phase_nxt = '0;
          w_done_nxt  = 1'b1;
          w_ready_nxt = 1'b1;
        end else begin
          w_phase_nxt = w_phase_inc;
          w_stcp_nxt  = 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_phase_nxt = '0;
        w_bit_nxt   = '0;
        w_ready_nxt = 1'b1;
      end
    endcase
  end

  // Control and pin registers; reset aborts a transfer before any stcp pulse.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= S_IDLE;
      r_phase <= '0;
      r_bit   <= '0;
      r_ds    <= 1'b0;
      r_shcp  <= 1'b0;
      r_stcp  <= 1'b0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_bit   <= w_bit_nxt;
      r_ds    <= w_ds_nxt;
      r_shcp  <= w_shcp_nxt;
      r_stcp  <= w_stcp_nxt;
      r_ready <= w_ready_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_ff @(posedge sys_clk) begin
    r_sr <= w_sr_nxt;
  end

  assign ds        = r_ds;
  assign shcp      = r_shcp;
  assign stcp      = r_stcp;
  assign bus.ready = r_ready;
  assign bus.done  = r_done;

`ifdef HC595_DIM_EN
  logic [7:0] r_pwm;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_pwm <= '0;
    else         r_pwm <= r_pwm + 8'd1;
  end

  // Outputs are lit while the free-running counter is below the brightness level.
  assign oe_n = sys_rst | ~(r_pwm < bright);
`else
  assign oe_n = sys_rst;
`endif

endmodule

// File: tb/tb_hc595_chain_tx.sv
// Self-checking bench for hc595_chain_tx: MSB-first and LSB-first instances compared cycle by cycle
// against a per-cycle timing model derived from the word, bit order and divider.
module tb_hc595_chain_tx;
  localparam int CW    = 14;
  localparam int DIV   = 4;
  localparam int HALF  = DIV / 2;
  localparam int NBITS = CW * DIV;
  localparam int TDONE = NBITS + HALF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hc595_chain_tx_if #(.CHAIN_W(CW)) bus_m ();
  hc595_chain_tx_if #(.CHAIN_W(CW)) bus_l ();

  logic ds_m, shcp_m, stcp_m, oe_m;
  logic ds_l, shcp_l, stcp_l, oe_l;
`ifdef HC595_DIM_EN
  logic [7:0] bright;
`endif

  hc595_chain_tx #(.CHAIN_W(CW), .DIV(DIV), .MSB_FIRST(1)) dut_m (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus_m),
`ifdef HC595_DIM_EN
    .bright  (bright),
`endif
    .ds      (ds_m),
    .shcp    (shcp_m),
    .stcp    (stcp_m),
    .oe_n    (oe_m)
  );

  hc595_chain_tx #(.CHAIN_W(CW), .DIV(DIV), .MSB_FIRST(0)) dut_l (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus_l),
`ifdef HC595_DIM_EN
    .bright  (bright),
`endif
    .ds      (ds_l),
    .shcp    (shcp_l),
    .stcp    (stcp_l),
    .oe_n    (oe_l)
  );

  wire [4:0] obs_m = {bus_m.ready, bus_m.done, ds_m, shcp_m, stcp_m};
  wire [4:0] obs_l = {bus_l.ready, bus_l.done, ds_l, shcp_l, stcp_l};

  int n_checks = 0;
  int n_errors = 0;

  // Expected {ready,done,ds,shcp,stcp} k cycles after the accepting edge.
  function automatic logic [4:0] model(input logic [CW-1:0] w, input bit msb, input int k);
    int   idx;
    logic b;
    logic s;
    if (k < NBITS) begin
      idx = k / DIV;
      b   = msb ? w[CW-1-idx] : w[idx];
      s   = ((k % DIV) >= HALF);
      return {1'b0, 1'b0, b, s, 1'b0};
    end else if (k < TDONE) begin
      return 5'b00001;
    end else if (k == TDONE) begin
      return 5'b11000;
    end
    return 5'b10000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    bus_m.load = 1'b0;
    bus_l.load = 1'b0;
    bus_m.din  = '0;
    bus_l.din  = '0;
`ifdef HC595_DIM_EN
    bright = 8'd255;
`endif
    repeat (3) tick();
    n_checks++;
    if (obs_m !== 5'b10000) begin
      $display("FAIL reset_outs_m: got %b expected %b", obs_m, 5'b10000); n_errors++;
    end
    n_checks++;
    if (obs_l !== 5'b10000) begin
      $display("FAIL reset_outs_l: got %b expected %b", obs_l, 5'b10000); n_errors++;
    end
    n_checks++;
    if (oe_m !== 1'b1 || oe_l !== 1'b1) begin
      $display("FAIL reset_oe_high: got %b%b expected 11", oe_m, oe_l); n_errors++;
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (oe_m !== 1'b0 || oe_l !== 1'b0) begin
      $display("FAIL release_oe_low: got %b%b expected 00", oe_m, oe_l); n_errors++;
    end
    tick();
    n_checks++;
    if (obs_m !== 5'b10000 || obs_l !== 5'b10000) begin
      $display("FAIL idle_after_release: got %b/%b expected 10000", obs_m, obs_l); n_errors++;
    end
  endtask

  task automatic test_msb_first();
    logic [CW-1:0] w;
    logic [CW-1:0] seq;
    int            rises;
    logic          prev;
    for (int n = 0; n < 4; n++) begin
      w = (n == 0) ? 14'h2A5C : CW'($urandom);
      bus_m.din  = w;
      bus_m.load = 1'b1;
      tick();
      bus_m.load = 1'b0;
      bus_m.din  = CW'($urandom);
      seq = '0; rises = 0; prev = 1'b0;
      for (int k = 0; k <= TDONE; k++) begin
        n_checks++;
        if (obs_m !== model(w, 1'b1, k)) begin
          $display("FAIL msb_cycle word=%h k=%0d: got %b expected %b", w, k, obs_m, model(w, 1'b1, k));
          n_errors++;
        end
        if (k < NBITS && (k % DIV) == 0) seq = {seq[CW-2:0], ds_m};
        if (shcp_m && !prev) rises++;
        prev = shcp_m;
        bus_m.din = CW'($urandom);
        if (k < TDONE) tick();
      end
      if (n == 0) begin
        n_checks++;
        if (seq !== 14'b10101001011100) begin
          $display("FAIL msb_ds_sequence: got %b expected %b", seq, 14'b10101001011100); n_errors++;
        end
      end
      n_checks++;
      if (rises != CW) begin
        $display("FAIL msb_shcp_edges: got %0d expected %0d", rises, CW); n_errors++;
      end
    end
  endtask

  task automatic test_lsb_first();
    logic [CW-1:0] w;
    logic [CW-1:0] seq;
    for (int n = 0; n < 4; n++) begin
      w = (n == 0) ? 14'h2A5C : CW'($urandom);
      bus_l.din  = w;
      bus_l.load = 1'b1;
      tick();
      bus_l.load = 1'b0;
      bus_l.din  = CW'($urandom);
      seq = '0;
      for (int k = 0; k <= TDONE; k++) begin
        n_checks++;
        if (obs_l !== model(w, 1'b0, k)) begin
          $display("FAIL lsb_cycle word=%h k=%0d: got %b expected %b", w, k, obs_l, model(w, 1'b0, k));
          n_errors++;
        end
        if (k < NBITS && (k % DIV) == 0) seq = {seq[CW-2:0], ds_l};
        if (k < TDONE) tick();
      end
      if (n == 0) begin
        n_checks++;
        if (seq !== 14'b00111010010101) begin
          $display("FAIL lsb_ds_sequence: got %b expected %b", seq, 14'b00111010010101); n_errors++;
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [CW-1:0] words [5];
    int   cyc;
    int   last_rise;
    logic prev;
    words[0] = 14'h3FFF; words[1] = 14'h0000; words[2] = 14'h3FFF; words[3] = 14'h0000;
    words[4] = CW'($urandom);
    cyc = 0; last_rise = -1; prev = 1'b0;
    bus_m.din  = words[0];
    bus_m.load = 1'b1;
    tick();
    for (int n = 0; n < 5; n++) begin
      for (int k = 0; k <= TDONE; k++) begin
        n_checks++;
        if (obs_m !== model(words[n], 1'b1, k)) begin
          $display("FAIL b2b_cycle n=%0d k=%0d: got %b expected %b", n, k, obs_m, model(words[n], 1'b1, k));
          n_errors++;
        end
        if (stcp_m && !prev) begin
          if (last_rise >= 0) begin
            n_checks++;
            if (cyc - last_rise != TDONE + 1) begin
              $display("FAIL b2b_stcp_period: got %0d expected %0d", cyc - last_rise, TDONE + 1); n_errors++;
            end
          end
          last_rise = cyc;
        end
        prev = stcp_m;
        if (k == TDONE) begin
          if (n < 4) bus_m.din = words[n+1];
          else       bus_m.load = 1'b0;
        end else begin
          bus_m.din = CW'($urandom);
        end
        if (!(n == 4 && k == TDONE)) begin
          tick();
          cyc++;
        end
      end
    end
    tick();
  endtask

  task automatic test_reset_abort();
    logic [CW-1:0] w;
    w = CW'($urandom);
    bus_m.din  = w;
    bus_m.load = 1'b1;
    tick();
    bus_m.load = 1'b0;
    for (int k = 0; k < 20; k++) begin
      n_checks++;
      if (obs_m !== model(w, 1'b1, k)) begin
        $display("FAIL abort_pre k=%0d: got %b expected %b", k, obs_m, model(w, 1'b1, k)); n_errors++;
      end
      if (k < 19) tick();
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (obs_m !== 5'b10000 || oe_m !== 1'b1) begin
      $display("FAIL abort_immediate: got %b oe=%b expected 10000 oe=1", obs_m, oe_m); n_errors++;
    end
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < TDONE + 10; k++) begin
      tick();
      n_checks++;
      if (obs_m !== 5'b10000) begin
        $display("FAIL abort_no_latch k=%0d: got %b expected 10000", k, obs_m); n_errors++;
      end
    end
    w = CW'($urandom);
    bus_m.din  = w;
    bus_m.load = 1'b1;
    tick();
    bus_m.load = 1'b0;
    for (int k = 0; k <= TDONE; k++) begin
      n_checks++;
      if (obs_m !== model(w, 1'b1, k)) begin
        $display("FAIL abort_fresh k=%0d: got %b expected %b", k, obs_m, model(w, 1'b1, k)); n_errors++;
      end
      if (k < TDONE) tick();
    end
    tick();
  endtask

`ifdef HC595_DIM_EN
  task automatic test_dim();
    int on_cnt;
    logic [7:0] levels [3];
    levels[0] = 8'd64; levels[1] = 8'd0; levels[2] = 8'($urandom);
    for (int j = 0; j < 3; j++) begin
      bright = levels[j];
      on_cnt = 0;
      for (int c = 0; c < 256; c++) begin
        if (oe_m === 1'b0) on_cnt++;
        tick();
      end
      n_checks++;
      if (on_cnt != int'(levels[j])) begin
        $display("FAIL dim_duty bright=%0d: got %0d expected %0d", levels[j], on_cnt, levels[j]); n_errors++;
      end
    end
    bright = 8'd255;
  endtask
`endif

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_reset_abort();
`ifdef HC595_DIM_EN
    test_dim();
    test_msb_first();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
